sym_fill_engine: RTL and testbench

SYM_FILL_ENGINE -- requirements
Module: sym_fill_engine

---
 rtl/sym_fill_engine.sv | 176 +++++++++++++++++
 tb/tb_sym_fill_engine.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sym_fill_engine.sv
// Rectangle fill engine: a processor programs position, size and color through
// four memory-mapped registers, then the engine writes the clipped rectangle into the framebuffer.
module sym_fill_engine #(
    parameter logic [31:0] REG_BASE = 32'h0000_0F00,
    parameter logic [31:0] FB_BASE  = 32'h0000_1000,
    parameter int          FB_W     = 640,
    parameter int          FB_H     = 480
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        WE,
    input  logic [31:0] A,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        vwe,
    output logic [31:0] vadr,
    output logic [31:0] vwd,
    input  logic        vready
);
    // Handshake: a framebuffer write completes on a rising edge where vwe=1 and
    // vready=1; while vwe=1 and vready=0, vwe/vadr/vwd hold and the column stays put.
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FILL, S_DONE} state_t;

    localparam logic [31:0] A_POS   = REG_BASE;
    localparam logic [31:0] A_SIZE  = REG_BASE + 32'd4;
    localparam logic [31:0] A_COLOR = REG_BASE + 32'd8;
    localparam logic [31:0] A_CTRL  = REG_BASE + 32'd12;

    state_t      state_q, state_d;
    logic [9:0]  pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic [9:0]  size_w_q, size_w_d, size_h_q, size_h_d;
    logic [7:0]  color_q, color_d;
    logic        done_q, done_d;
    logic [9:0]  wx_q, wx_d, wy_q, wy_d, ww_q, ww_d, wh_q, wh_d;
    logic [7:0]  wcolor_q, wcolor_d;
    logic [9:0]  row_q, row_d, col_q, col_d;
    logic [31:0] row_adr_q, row_adr_d;

    logic        busy;
    logic        start;
    logic [10:0] px;
    logic [10:0] cy;
    logic        pix_vis;
    logic [31:0] row_calc;
    logic        unused_wd;

    assign busy      = (state_q != S_IDLE);
    assign start     = WE && (A == A_CTRL) && WD[0] && !busy;
    // 11-bit sums so coordinates past 1023 never alias back into the visible area
    assign px        = {1'b0, wx_q} + {1'b0, col_q};
    assign cy        = {1'b0, wy_q} + {1'b0, row_q};
    assign pix_vis   = (px < 11'(FB_W)) && (cy < 11'(FB_H));
    assign row_calc  = FB_BASE + (((32'(cy) * 32'(FB_W)) + 32'(wx_q)) << 2);
    assign unused_wd = ^{WD[31:26], WD[15:10]};

    always_comb begin
        RD = 32'd0;
        if (A == A_POS)        RD = {6'b0, pos_y_q, 6'b0, pos_x_q};
        else if (A == A_SIZE)  RD = {6'b0, size_h_q, 6'b0, size_w_q};
        else if (A == A_COLOR) RD = {24'b0, color_q};
        else if (A == A_CTRL)  RD = {30'b0, done_q, busy};
    end

    always_comb begin
        state_d   = state_q;
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        size_w_d  = size_w_q;
        size_h_d  = size_h_q;
        color_d   = color_q;
        done_d    = done_q;
        wx_d      = wx_q;
        wy_d      = wy_q;
        ww_d      = ww_q;
        wh_d      = wh_q;
        wcolor_d  = wcolor_q;
        row_d     = row_q;
        col_d     = col_q;
        row_adr_d = row_adr_q;
        vwe       = 1'b0;
        vadr      = 32'd0;
        vwd       = 32'd0;

        if (WE && !busy) begin
            if (A == A_POS) begin
                pos_x_d = WD[9:0];
                pos_y_d = WD[25:16];
            end else if (A == A_SIZE) begin
                size_w_d = WD[9:0];
                size_h_d = WD[25:16];
            end else if (A == A_COLOR) begin
                color_d = WD[7:0];
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    wx_d     = pos_x_q;
                    wy_d     = pos_y_q;
                    ww_d     = size_w_q;
                    wh_d     = size_h_q;
                    wcolor_d = color_q;
                    row_d    = 10'd0;
                    col_d    = 10'd0;
                    done_d   = 1'b0;
                    state_d  = (size_w_q == 10'd0 || size_h_q == 10'd0) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                row_adr_d = row_calc;
                state_d   = S_FILL;
            end
            S_FILL: begin
                vwe  = pix_vis;
                vadr = row_adr_q + {20'b0, col_q, 2'b00};
                vwd  = {24'b0, wcolor_q};
                // clipped pixels never wait on vready
                if (!pix_vis || vready) begin
                    if (col_q == ww_q - 10'd1) begin
                        col_d = 10'd0;
                        if (row_q == wh_q - 10'd1) begin
                            state_d = S_DONE;
                        end else begin
                            row_d   = row_q + 10'd1;
                            state_d = S_CALC;
                        end
                    end else begin
                        col_d = col_q + 10'd1;
                    end
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pos_x_q   <= '0;
            pos_y_q   <= '0;
            size_w_q  <= '0;
            size_h_q  <= '0;
            color_q   <= '0;
            done_q    <= 1'b0;
            wx_q      <= '0;
            wy_q      <= '0;
            ww_q      <= '0;
            wh_q      <= '0;
            wcolor_q  <= '0;
            row_q     <= '0;
            col_q     <= '0;
            row_adr_q <= '0;
        end else begin
            state_q   <= state_d;
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
            size_w_q  <= size_w_d;
            size_h_q  <= size_h_d;
            color_q   <= color_d;
            done_q    <= done_d;
            wx_q      <= wx_d;
            wy_q      <= wy_d;
            ww_q      <= ww_d;
            wh_q      <= wh_d;
            wcolor_q  <= wcolor_d;
            row_q     <= row_d;
            col_q     <= col_d;
            row_adr_q <= row_adr_d;
        end
    end
endmodule

// File: tb/tb_sym_fill_engine.sv
// Directed bench for sym_fill_engine: register vector table plus fill, clip,
// stall, busy-interference and mid-fill reset sequences against a pixel model.
module tb_sym_fill_engine;
  localparam logic [31:0] REG_BASE = 32'h0000_0F00;
  localparam logic [31:0] FB_BASE  = 32'h0000_1000;
  localparam logic [31:0] A_POS    = REG_BASE;
  localparam logic [31:0] A_SIZE   = REG_BASE + 32'd4;
  localparam logic [31:0] A_COLOR  = REG_BASE + 32'd8;
  localparam logic [31:0] A_CTRL   = REG_BASE + 32'd12;

  logic        CLK = 1'b0;
  logic        reset, WE, vwe, vready;
  logic [31:0] A, WD, RD, vadr, vwd;

  logic [31:0] exp_q[$];
  int total = 0;
  int bad = 0;

  sym_fill_engine dut (
    .CLK(CLK), .reset(reset), .WE(WE), .A(A), .WD(WD), .RD(RD),
    .vwe(vwe), .vadr(vadr), .vwd(vwd), .vready(vready)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        we;
    logic [31:0] wa;
    logic [31:0] wd;
    logic [31:0] ra;
    logic [31:0] exp;
  } reg_vec_t;

  reg_vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic write_reg(input logic [31:0] addr, input logic [31:0] data);
    WE = 1'b1; A = addr; WD = data;
    tick();
    WE = 1'b0; A = A_CTRL; WD = 32'd0;
  endtask

  // Expected framebuffer writes of a fill, in issue order
  task automatic build_exp(input int x, input int y, input int w, input int h);
    exp_q.delete();
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        if ((x + c) < 640 && (y + r) < 480)
          exp_q.push_back(FB_BASE + 32'(((y + r) * 640 + x + c) * 4));
  endtask

  task automatic fill_case(input string name, input int x, input int y, input int w, input int h,
                           input logic [7:0] color, input int stall, input int interfere,
                           input int exp_first);
    int busy_cycles = 0;
    int first_vwe = -1;
    int stable = 0;
    int stall_left = stall;
    int nwr = 0;
    int exp_wr;
    int exp_busy;
    logic busy;
    logic finished = 1'b0;

    write_reg(A_POS, {6'b0, 10'(y), 6'b0, 10'(x)});
    write_reg(A_SIZE, {6'b0, 10'(h), 6'b0, 10'(w)});
    write_reg(A_COLOR, {24'b0, color});
    build_exp(x, y, w, h);
    exp_wr = exp_q.size();
    exp_busy = (w == 0 || h == 0) ? 1 : h * (w + 1) + 1 + stall;
    vready = 1'b1;
    write_reg(A_CTRL, 32'd1);

    for (int cyc = 1; cyc <= 2000; cyc++) begin
      if (interfere != 0 && cyc == 1) begin
        WE = 1'b1; A = A_COLOR; WD = 32'h0000_0022;
      end else if (interfere != 0 && cyc == 2) begin
        WE = 1'b1; A = A_CTRL; WD = 32'd1;
      end else begin
        WE = 1'b0; A = A_CTRL; WD = 32'd0;
      end
      #1;
      busy = (interfere != 0 && cyc == 1) ? 1'b1 : RD[0];
      if (cyc == 1 && interfere == 0) check({name, " stat_first"}, RD, 32'd1);
      if (!busy) begin
        finished = 1'b1;
        break;
      end
      busy_cycles++;
      if (vwe) begin
        if (first_vwe < 0) first_vwe = cyc;
        check({name, " have_exp"}, 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check({name, " vadr"}, vadr, exp_q[0]);
        check({name, " vwd"}, vwd, {24'b0, color});
        if (nwr == 0 && stall_left > 0) begin
          vready = 1'b0;
          stall_left--;
          stable++;
        end else begin
          vready = 1'b1;
          if (nwr == 0) stable++;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          nwr++;
        end
      end else begin
        vready = 1'b1;
      end
      tick();
    end
    WE = 1'b0; A = A_CTRL; WD = 32'd0; vready = 1'b1;

    check({name, " finished"}, 32'(finished), 32'd1);
    check({name, " busy_cycles"}, 32'(busy_cycles), 32'(exp_busy));
    check({name, " writes"}, 32'(nwr), 32'(exp_wr));
    check({name, " leftover"}, 32'(exp_q.size()), 32'd0);
    check({name, " first_vwe"}, 32'(first_vwe), 32'(exp_first));
    if (stall > 0) check({name, " stall_hold"}, 32'(stable), 32'(stall + 1));
    A = A_CTRL; #1;
    check({name, " stat_end"}, RD, 32'd2);
    A = A_COLOR; #1;
    check({name, " color_kept"}, RD, {24'b0, color});
    A = A_CTRL;
  endtask

  initial begin
    int vwe_seen;

    vecs[0] = '{1'b1, A_POS,          32'h0001_0002, A_POS,          32'h0001_0002};
    vecs[1] = '{1'b1, A_POS,          32'hFFFF_FFFF, A_POS,          32'h03FF_03FF};
    vecs[2] = '{1'b1, A_SIZE,         32'h0002_0003, A_SIZE,         32'h0002_0003};
    vecs[3] = '{1'b1, A_COLOR,        32'h1234_56E3, A_COLOR,        32'h0000_00E3};
    vecs[4] = '{1'b1, REG_BASE + 1,   32'h0000_0000, A_POS,          32'h03FF_03FF};
    vecs[5] = '{1'b0, 32'd0,          32'd0,         REG_BASE + 16,  32'd0};
    vecs[6] = '{1'b0, 32'd0,          32'd0,         REG_BASE - 4,   32'd0};
    vecs[7] = '{1'b0, 32'd0,          32'd0,         A_CTRL,         32'd0};
    vecs[8] = '{1'b1, A_CTRL,         32'hFFFF_FFFE, A_CTRL,         32'd0};

    reset = 1'b1; WE = 1'b0; A = 32'd0; WD = 32'd0; vready = 1'b1;
    repeat (3) tick();
    check("rst vwe", 32'(vwe), 32'd0);
    check("rst vadr", vadr, 32'd0);
    check("rst vwd", vwd, 32'd0);
    A = A_CTRL; #1;
    check("rst stat", RD, 32'd0);
    A = A_POS; #1;
    check("rst pos", RD, 32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].we) write_reg(vecs[i].wa, vecs[i].wd);
      A = vecs[i].ra; #1;
      check($sformatf("regvec%0d", i), RD, vecs[i].exp);
      tick();
    end

    fill_case("basic",   2,   1,   3, 2, 8'hE3, 0, 0, 2);
    fill_case("clip",    638, 479, 4, 2, 8'h5A, 0, 0, 2);
    fill_case("zero",    7,   9,   0, 5, 8'h3C, 0, 0, -1);
    fill_case("stall",   10,  20,  4, 3, 8'h77, 3, 0, 2);
    fill_case("busywr",  5,   5,   3, 1, 8'h11, 0, 1, 2);
    fill_case("offview", 700, 10,  2, 2, 8'h99, 0, 0, -1);

    write_reg(A_POS, 32'd0);
    write_reg(A_SIZE, {6'b0, 10'd10, 6'b0, 10'd10});
    write_reg(A_COLOR, 32'h44);
    vready = 1'b1;
    write_reg(A_CTRL, 32'd1);
    tick();
    check("rstfill fill1 vwe", 32'(vwe), 32'd1);
    tick();
    check("rstfill fill2 vwe", 32'(vwe), 32'd1);
    reset = 1'b1; WE = 1'b1; A = A_CTRL; WD = 32'd1;
    tick();
    reset = 1'b0; WE = 1'b0; WD = 32'd0;
    check("rstfill vwe", 32'(vwe), 32'd0);
    A = A_CTRL; #1;
    check("rstfill stat", RD, 32'd0);
    A = A_POS; #1;
    check("rstfill pos", RD, 32'd0);
    vwe_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (vwe) vwe_seen++;
      tick();
    end
    check("rstfill no_vwe", 32'(vwe_seen), 32'd0);
    A = A_CTRL; #1;
    check("rstfill stat_later", RD, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
